scan_decoder: RTL and testbench

Parametrised, registered N-to-2^N one-hot decoder with active-high enable and an auto-scan mode. It generalises the 2-to-4 enable decoder to ADDR_WIDTH address bits and adds a clocked sweep. In the sweep, a dwell counter steps the selected output through every position, holding each one for a programmable number of cycles. It sits between control logic and row/bank/channel select lines, either as a direct address decoder or as a free-running select scanner.

---
 rtl/decoder_pkg.sv | 15 +
 rtl/onehot_decoder.sv | 16 +
 rtl/scan_decoder.sv | 79 +++++++
 tb/tb_scan_decoder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared constants and helpers for the scan decoder family.
package decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // A counter for DWELL states needs clog2(DWELL) bits.
    // DWELL = 1 would give zero bits, so clamp the result to at least one bit.
    function automatic int dwell_cnt_width(input int dwell);
        int w;
        w = $clog2(dwell);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Combinational N-to-2^N one-hot decoder with active-high enable.
module onehot_decoder #(
    parameter int ADDR_WIDTH = 2,
    localparam int OUT_WIDTH = 2 ** ADDR_WIDTH
) (
    input  logic                  enable,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [OUT_WIDTH-1:0]  out
);

    // Each output bit compares addr against its own index.
    for (genvar gi = 0; gi < OUT_WIDTH; gi++) begin : g_bit
        assign out[gi] = enable && (addr == ADDR_WIDTH'(gi));
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with direct-decode and dwell-timed auto-scan modes.
module scan_decoder
    import decoder_pkg::*;
#(
    parameter int ADDR_WIDTH = 2,
    parameter int DWELL      = 1,
    localparam int OUT_WIDTH = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  mode,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [OUT_WIDTH-1:0]  out,
    output logic [ADDR_WIDTH-1:0] cur_addr,
    output logic                  wrap
);

    localparam int             CNT_W      = dwell_cnt_width(DWELL);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [CNT_W-1:0]      dwell_cnt_q, dwell_cnt_d;
    logic [OUT_WIDTH-1:0]  out_q, out_d;
    logic                  wrap_q, wrap_d;

    // The decoder always looks at the next address, so out_q and cur_addr_q
    // update on the same edge and out stays onehot(cur_addr) when non-zero.
    onehot_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_onehot (
        .enable (enable),
        .addr   (cur_addr_d),
        .out    (out_d)
    );

    // Next-state selection: enable gate, then direct decode or scan priority.
    always_comb begin
        cur_addr_d  = cur_addr_q;
        dwell_cnt_d = dwell_cnt_q;
        wrap_d      = 1'b0;
        if (enable) begin
            if (mode == MODE_DIRECT) begin
                cur_addr_d  = addr;
                dwell_cnt_d = '0;
            end else if (load) begin
                cur_addr_d  = addr;
                dwell_cnt_d = '0;
            end else if (dwell_cnt_q == DWELL_LAST) begin
                dwell_cnt_d = '0;
                cur_addr_d  = cur_addr_q + ADDR_WIDTH'(1);
                wrap_d      = &cur_addr_q;
            end else begin
                dwell_cnt_d = dwell_cnt_q + CNT_W'(1);
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_addr_q  <= '0;
            dwell_cnt_q <= '0;
            out_q       <= '0;
            wrap_q      <= 1'b0;
        end else begin
            cur_addr_q  <= cur_addr_d;
            dwell_cnt_q <= dwell_cnt_d;
            out_q       <= out_d;
            wrap_q      <= wrap_d;
        end
    end

    assign out      = out_q;
    assign cur_addr = cur_addr_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench for scan_decoder: ADDR_WIDTH=2/DWELL=3 and ADDR_WIDTH=3/DWELL=1.
module tb_scan_decoder;

    typedef struct packed {
        logic [7:0] o;
        logic [2:0] a;
        logic       w;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    logic       clk = 1'b0;
    logic       reset;
    logic       en, mode, load;
    logic [1:0] addr;
    logic [3:0] out;
    logic [1:0] cur_addr;
    logic       wrap;

    logic       en8, mode8, load8;
    logic [2:0] addr8;
    logic [7:0] out8;
    logic [2:0] cur8;
    logic       wrap8;

    always #5 clk = ~clk;

    scan_decoder #(.ADDR_WIDTH(2), .DWELL(3)) dut (
        .clk(clk), .reset(reset), .enable(en), .mode(mode), .load(load),
        .addr(addr), .out(out), .cur_addr(cur_addr), .wrap(wrap)
    );

    scan_decoder #(.ADDR_WIDTH(3), .DWELL(1)) dut8 (
        .clk(clk), .reset(reset), .enable(en8), .mode(mode8), .load(load8),
        .addr(addr8), .out(out8), .cur_addr(cur8), .wrap(wrap8)
    );

    function automatic exp_t mk(input int o_idx, input int a, input logic w);
        exp_t e;
        e.o = (o_idx < 0) ? 8'h00 : (8'h01 << o_idx);
        e.a = 3'(a);
        e.w = w;
        return e;
    endfunction

    task automatic test_reset();
        exp_t g;
        reset = 1'b1; en = 1'b1; mode = 1'b1; load = 1'b1; addr = 2'd3;
        en8 = 1'b1; mode8 = 1'b1; load8 = 1'b1; addr8 = 3'd5;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(mk(-1, 0, 1'b0));
            @(posedge clk); #1;
            g = sb.pop_front();
            checks++;
            if (out !== g.o[3:0] || cur_addr !== g.a[1:0] || wrap !== g.w) begin
                errors++;
                $display("FAIL reset[%0d]: got out=%b cur=%0d wrap=%b, want out=%b cur=%0d wrap=%b",
                         i, out, cur_addr, wrap, g.o[3:0], g.a[1:0], g.w);
            end else $display("reset[%0d] ok out=%b cur=%0d", i, out, cur_addr);
            checks++;
            if (out8 !== 8'h00 || cur8 !== 3'd0 || wrap8 !== 1'b0) begin
                errors++;
                $display("FAIL reset8[%0d]: got out=%b cur=%0d wrap=%b, want out=0 cur=0 wrap=0",
                         i, out8, cur8, wrap8);
            end else $display("reset8[%0d] ok", i);
        end
        reset = 1'b0; en = 1'b0; en8 = 1'b0; load8 = 1'b0;
    endtask

    task automatic test_direct();
        exp_t g;
        for (int i = 0; i < 4; i++) begin
            en = 1'b1; mode = 1'b0; load = 1'(i % 2); addr = 2'(i);
            sb.push_back(mk(i, i, 1'b0));
            @(posedge clk); #1;
            g = sb.pop_front();
            checks++;
            if (out !== g.o[3:0] || cur_addr !== g.a[1:0] || wrap !== g.w) begin
                errors++;
                $display("FAIL direct[%0d]: got out=%b cur=%0d wrap=%b, want out=%b cur=%0d wrap=%b",
                         i, out, cur_addr, wrap, g.o[3:0], g.a[1:0], g.w);
            end else $display("direct[%0d] ok out=%b", i, out);
        end
    endtask

    task automatic test_enable_gating();
        exp_t g;
        for (int i = 0; i < 8; i++) begin
            en = 1'b0; mode = 1'(i / 4); load = 1'(i % 2); addr = 2'(i);
            sb.push_back(mk(-1, 3, 1'b0));
            @(posedge clk); #1;
            g = sb.pop_front();
            checks++;
            if (out !== g.o[3:0] || cur_addr !== g.a[1:0] || wrap !== g.w) begin
                errors++;
                $display("FAIL gating[%0d]: got out=%b cur=%0d wrap=%b, want out=%b cur=%0d wrap=%b",
                         i, out, cur_addr, wrap, g.o[3:0], g.a[1:0], g.w);
            end else $display("gating[%0d] ok out=%b cur=%0d", i, out, cur_addr);
        end
    endtask

    task automatic test_scan_sweep();
        exp_t g;
        int a;
        for (int k = 0; k <= 12; k++) begin
            en = 1'b1; mode = 1'b1; load = (k == 0); addr = 2'd2;
            a = (2 + k / 3) % 4;
            sb.push_back(mk(a, a, (k > 0) && (k % 3 == 0) && (a == 0)));
            @(posedge clk); #1;
            g = sb.pop_front();
            checks++;
            if (out !== g.o[3:0] || cur_addr !== g.a[1:0] || wrap !== g.w) begin
                errors++;
                $display("FAIL sweep[%0d]: got out=%b cur=%0d wrap=%b, want out=%b cur=%0d wrap=%b",
                         k, out, cur_addr, wrap, g.o[3:0], g.a[1:0], g.w);
            end else $display("sweep[%0d] ok out=%b wrap=%b", k, out, wrap);
        end
        load = 1'b0;
    endtask

    task automatic test_freeze_resume();
        exp_t g;
        // load 1, one dwell cycle, 5 frozen cycles, two resumed cycles
        int   en_t[9]  = '{1, 1, 0, 0, 0, 0, 0, 1, 1};
        int   out_t[9] = '{1, 1, -1, -1, -1, -1, -1, 1, 2};
        int   cur_t[9] = '{1, 1, 1, 1, 1, 1, 1, 1, 2};
        for (int i = 0; i < 9; i++) begin
            en = 1'(en_t[i]); mode = 1'b1; load = (i == 0); addr = 2'd1;
            sb.push_back(mk(out_t[i], cur_t[i], 1'b0));
            @(posedge clk); #1;
            g = sb.pop_front();
            checks++;
            if (out !== g.o[3:0] || cur_addr !== g.a[1:0] || wrap !== g.w) begin
                errors++;
                $display("FAIL freeze[%0d]: got out=%b cur=%0d wrap=%b, want out=%b cur=%0d wrap=%b",
                         i, out, cur_addr, wrap, g.o[3:0], g.a[1:0], g.w);
            end else $display("freeze[%0d] ok out=%b en=%b", i, out, en);
        end
    endtask

    task automatic test_priority_mode_switch();
        exp_t g;
        // load 3, dwell to last, load 0 (no wrap), direct 3, back to scan from 3
        int   md_t[8]  = '{1, 1, 1, 1, 0, 1, 1, 1};
        int   ld_t[8]  = '{1, 0, 0, 1, 0, 0, 0, 0};
        int   ad_t[8]  = '{3, 0, 0, 0, 3, 1, 1, 1};
        int   cur_t[8] = '{3, 3, 3, 0, 3, 3, 3, 0};
        int   wr_t[8]  = '{0, 0, 0, 0, 0, 0, 0, 1};
        for (int i = 0; i < 8; i++) begin
            en = 1'b1; mode = 1'(md_t[i]); load = 1'(ld_t[i]); addr = 2'(ad_t[i]);
            sb.push_back(mk(cur_t[i], cur_t[i], 1'(wr_t[i])));
            @(posedge clk); #1;
            g = sb.pop_front();
            checks++;
            if (out !== g.o[3:0] || cur_addr !== g.a[1:0] || wrap !== g.w) begin
                errors++;
                $display("FAIL prio[%0d]: got out=%b cur=%0d wrap=%b, want out=%b cur=%0d wrap=%b",
                         i, out, cur_addr, wrap, g.o[3:0], g.a[1:0], g.w);
            end else $display("prio[%0d] ok out=%b wrap=%b", i, out, wrap);
        end
        load = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        exp_t g;
        int   rs_t[5]  = '{0, 1, 0, 0, 0};
        int   out_t[5] = '{2, -1, 0, 0, 1};
        int   cur_t[5] = '{2, 0, 0, 0, 1};
        for (int i = 0; i < 5; i++) begin
            reset = 1'(rs_t[i]); en = 1'b1; mode = 1'b1; load = (i == 0); addr = 2'd2;
            sb.push_back(mk(out_t[i], cur_t[i], 1'b0));
            @(posedge clk); #1;
            g = sb.pop_front();
            checks++;
            if (out !== g.o[3:0] || cur_addr !== g.a[1:0] || wrap !== g.w) begin
                errors++;
                $display("FAIL midreset[%0d]: got out=%b cur=%0d wrap=%b, want out=%b cur=%0d wrap=%b",
                         i, out, cur_addr, wrap, g.o[3:0], g.a[1:0], g.w);
            end else $display("midreset[%0d] ok out=%b cur=%0d", i, out, cur_addr);
        end
        reset = 1'b0; en = 1'b0;
    endtask

    task automatic test_param_sweep();
        exp_t g;
        int a;
        for (int k = 0; k <= 24; k++) begin
            en8 = 1'b1; mode8 = 1'b1; load8 = (k == 0); addr8 = 3'd5;
            a = (5 + k) % 8;
            sb.push_back(mk(a, a, (k > 0) && (a == 0)));
            @(posedge clk); #1;
            g = sb.pop_front();
            checks++;
            if (out8 !== g.o || cur8 !== g.a || wrap8 !== g.w || !$onehot(out8)) begin
                errors++;
                $display("FAIL sweep8[%0d]: got out=%b cur=%0d wrap=%b, want out=%b cur=%0d wrap=%b",
                         k, out8, cur8, wrap8, g.o, g.a, g.w);
            end else $display("sweep8[%0d] ok out=%b wrap=%b", k, out8, wrap8);
        end
        en8 = 1'b0; load8 = 1'b0;
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; mode = 1'b0; load = 1'b0; addr = '0;
        en8 = 1'b0; mode8 = 1'b0; load8 = 1'b0; addr8 = '0;
        @(posedge clk); #1;
        test_reset();
        test_direct();
        test_enable_gating();
        test_scan_sweep();
        test_freeze_resume();
        test_priority_mode_switch();
        test_reset_mid_scan();
        test_param_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

endmodule
